frequency_window_controller: RTL and testbench

Sequences the two-tone frequency analyzer through fixed measurement windows. Each window clears and enables the analyzer for a programmable number of clock ticks, then freezes it and captures both accumulated tick counts. It classifies the window as tone 1, tone 2 or no tone, and presents the result on a valid/ready handshake. The block sits between the analyzer (which it drives and reads) and the downstream symbol consumer (FSK decoder / capture FSM).

---
 rtl/frequency_window_controller.sv | 166 ++++++++++++++++
 tb/tb_frequency_window_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_window_controller.sv
// frequency_window_controller
// Runs the two-tone analyzer through fixed-length measurement windows:
// clear, measure, freeze and capture, classify, then hand the symbol to the
// downstream consumer over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | analyzer off, waiting for start
// CLEAR   | two cycles of analyzer clear (enable held so the clear takes)
// MEASURE | analyzer counting for WINDOW_TICKS cycles
// CAPTURE | analyzer frozen for one cycle, counts latched at its end
// RESULT  | symbol and captured counts presented until accepted
module frequency_window_controller #(
    parameter int unsigned WINDOW_TICKS = 500000,
    parameter int unsigned MIN_TICKS    = 50000
) (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic        i_abort,
    output logic        o_analyzer_enable,
    output logic        o_analyzer_clear,
    input  logic [31:0] i_f1_value,
    input  logic [31:0] i_f2_value,
    output logic        o_result_valid,
    input  logic        i_result_ready,
    output logic [1:0]  o_symbol,
    output logic [31:0] o_f1_captured,
    output logic [31:0] o_f2_captured,
    output logic        o_busy
);

    // Counter must be able to hold WINDOW_TICKS itself (it increments on the
    // last measure cycle as well).
    localparam int CW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS + 1) : 1;
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_TICKS - 1);
    localparam logic [31:0]   MIN_VAL  = 32'(MIN_TICKS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        MEASURE = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } state_t;

    state_t         r_state;
    logic           r_clr_phase;
    logic [CW-1:0]  r_win_cnt;
    logic           r_enable;
    logic           r_an_clear;
    logic           r_valid;
    logic           r_busy;
    logic [1:0]     r_symbol;
    logic [31:0]    r_f1_cap;
    logic [31:0]    r_f2_cap;

    logic           w_f1_wins;
    logic           w_f2_wins;
    logic [1:0]     w_symbol;

    // Classification of the live analyzer counts; ties and sub-threshold
    // counts resolve to "no tone".
    always_comb begin
        w_f1_wins = (i_f1_value >= MIN_VAL) && (i_f1_value > i_f2_value);
        w_f2_wins = (i_f2_value >= MIN_VAL) && (i_f2_value > i_f1_value);
        w_symbol  = 2'd0;
        if (w_f1_wins) begin
            w_symbol = 2'd1;
        end else if (w_f2_wins) begin
            w_symbol = 2'd2;
        end
    end

    // Window sequencer with registered outputs; abort overrides everything.
    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state     <= IDLE;
            r_clr_phase <= 1'b0;
            r_win_cnt   <= '0;
            r_enable    <= 1'b0;
            r_an_clear  <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_symbol    <= 2'd0;
            r_f1_cap    <= 32'd0;
            r_f2_cap    <= 32'd0;
        end else if (i_abort) begin
            // Captured values and symbol are kept; only the handshake drops.
            r_state     <= IDLE;
            r_clr_phase <= 1'b0;
            r_enable    <= 1'b0;
            r_an_clear  <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= CLEAR;
                        r_clr_phase <= 1'b0;
                        r_win_cnt   <= '0;
                        r_enable    <= 1'b1;
                        r_an_clear  <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_win_cnt <= '0;
                    if (!r_clr_phase) begin
                        r_clr_phase <= 1'b1;
                    end else begin
                        r_state    <= MEASURE;
                        r_an_clear <= 1'b0;
                    end
                end
                MEASURE: begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    if (r_win_cnt == WIN_LAST) begin
                        r_state  <= CAPTURE;
                        r_enable <= 1'b0;
                    end
                end
                CAPTURE: begin
                    r_f1_cap <= i_f1_value;
                    r_f2_cap <= i_f2_value;
                    r_symbol <= w_symbol;
                    r_valid  <= 1'b1;
                    r_state  <= RESULT;
                end
                RESULT: begin
                    if (r_valid && i_result_ready) begin
                        r_valid <= 1'b0;
                        if (i_continuous) begin
                            r_state     <= CLEAR;
                            r_clr_phase <= 1'b0;
                            r_win_cnt   <= '0;
                            r_enable    <= 1'b1;
                            r_an_clear  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_enable   <= 1'b0;
                    r_an_clear <= 1'b0;
                    r_valid    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_analyzer_enable = r_enable;
    assign o_analyzer_clear  = r_an_clear;
    assign o_result_valid    = r_valid;
    assign o_symbol          = r_symbol;
    assign o_f1_captured     = r_f1_cap;
    assign o_f2_captured     = r_f2_cap;
    assign o_busy            = r_busy;

endmodule

// File: tb/tb_frequency_window_controller.sv
// Testbench for frequency_window_controller (WINDOW_TICKS=100, MIN_TICKS=20).
// Expected results are queued when a window is launched and popped by an
// independent monitor whenever the DUT completes a handshake.
module tb_frequency_window_controller;

    localparam int W = 100;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic        an_en;
    logic        an_clr;
    logic [31:0] f1 = 32'd0;
    logic [31:0] f2 = 32'd0;
    logic        valid;
    logic        ready = 1'b1;
    logic [1:0]  symbol;
    logic [31:0] f1_cap;
    logic [31:0] f2_cap;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  sym;
        logic [31:0] f1;
        logic [31:0] f2;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [31:0] f1;
        logic [31:0] f2;
        logic [1:0]  sym;
    } vec_t;
    vec_t vecs[9] = '{
        '{32'd60,         32'd10,         2'd1},
        '{32'd5,          32'd40,         2'd2},
        '{32'd30,         32'd30,         2'd0},
        '{32'd15,         32'd0,          2'd0},
        '{32'hFFFFFFFF,   32'd0,          2'd1},
        '{32'd20,         32'd19,         2'd1},
        '{32'd19,         32'd0,          2'd0},
        '{32'd0,          32'd20,         2'd2},
        '{32'd100,        32'hFFFFFFFF,   2'd2}
    };

    frequency_window_controller #(
        .WINDOW_TICKS(W),
        .MIN_TICKS(20)
    ) dut (
        .i_clock(clk),
        .i_clear(clear),
        .i_start(start),
        .i_continuous(continuous),
        .i_abort(abort),
        .o_analyzer_enable(an_en),
        .o_analyzer_clear(an_clr),
        .i_f1_value(f1),
        .i_f2_value(f2),
        .o_result_valid(valid),
        .i_result_ready(ready),
        .o_symbol(symbol),
        .o_f1_captured(f1_cap),
        .o_f2_captured(f2_cap),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid && n < 3 * W) begin
            tick();
            n++;
        end
        if (!valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for result_valid got 0 expected 1", name);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " en"},     an_en,  0);
        chk({tag, " clr"},    an_clr, 0);
        chk({tag, " valid"},  valid,  0);
        chk({tag, " symbol"}, symbol, 0);
        chk({tag, " f1cap"},  f1_cap, 0);
        chk({tag, " f2cap"},  f2_cap, 0);
        chk({tag, " busy"},   busy,   0);
    endtask

    // Scoreboard monitor: a handshake is due at the next edge whenever
    // valid and ready are both high mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (valid && ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got symbol %0d f1 %0h f2 %0h expected no result",
                             symbol, f1_cap, f2_cap);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb symbol", symbol, e.sym);
                    chk("sb f1cap",  f1_cap, e.f1);
                    chk("sb f2cap",  f2_cap, e.f2);
                end
            end
        end
    end

    // Directed stimulus and cycle-accurate timing checks.
    initial begin
        int vt[3];
        int pulses;
        int clr_total;
        logic clr_log[0:399];

        #3;
        check_all_zero("reset");
        @(negedge clk);
        clear = 1'b0;
        tick();

        // Single shot with exact cycle numbering.
        f1 = 32'd60;
        f2 = 32'd10;
        sb_q.push_back('{2'd1, 32'd60, 32'd10});
        pulse_start();
        for (int c = 1; c <= W + 6; c++) begin
            chk($sformatf("shot clr c%0d", c),   an_clr, (c >= 1 && c <= 2));
            chk($sformatf("shot en c%0d", c),    an_en,  (c >= 1 && c <= W + 2));
            chk($sformatf("shot valid c%0d", c), valid,  (c == W + 4));
            if (c == W + 5) chk("shot busy idle", busy, 0);
            tick();
        end

        // Classification vectors.
        foreach (vecs[i]) begin
            f1 = vecs[i].f1;
            f2 = vecs[i].f2;
            sb_q.push_back('{vecs[i].sym, vecs[i].f1, vecs[i].f2});
            pulse_start();
            wait_valid($sformatf("class%0d", i));
            tick();
            chk($sformatf("class%0d valid drop", i), valid, 0);
            chk($sformatf("class%0d busy", i), busy, 0);
        end

        // Backpressure: result held while inputs move underneath it.
        ready = 1'b0;
        f1 = 32'd5;
        f2 = 32'd40;
        sb_q.push_back('{2'd2, 32'd5, 32'd40});
        pulse_start();
        wait_valid("bp");
        f1 = 32'd999;
        f2 = 32'd1;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("bp valid k%0d", k),  valid,  1);
            chk($sformatf("bp en k%0d", k),     an_en,  0);
            chk($sformatf("bp symbol k%0d", k), symbol, 2);
            chk($sformatf("bp f1cap k%0d", k),  f1_cap, 5);
            chk($sformatf("bp f2cap k%0d", k),  f2_cap, 40);
        end
        ready = 1'b1;
        tick();
        chk("bp valid drop", valid, 0);
        chk("bp busy", busy, 0);

        // Continuous: three back-to-back windows.
        f1 = 32'd0;
        f2 = 32'd20;
        for (int k = 0; k < 3; k++) sb_q.push_back('{2'd2, 32'd0, 32'd20});
        for (int c = 0; c < 400; c++) clr_log[c] = 1'b0;
        pulses = 0;
        vt = '{0, 0, 0};
        continuous = 1'b1;
        pulse_start();
        for (int c = 1; c < 400 && pulses < 3; c++) begin
            clr_log[c] = an_clr;
            if (valid) begin
                vt[pulses] = c;
                pulses++;
                if (pulses == 3) continuous = 1'b0;
            end
            tick();
        end
        chk("cont pulses", pulses, 3);
        chk("cont first valid", vt[0], W + 4);
        chk("cont period 1", vt[1] - vt[0], W + 4);
        chk("cont period 2", vt[2] - vt[1], W + 4);
        clr_total = 0;
        for (int c = 0; c < 400; c++) clr_total += int'(clr_log[c]);
        chk("cont clr cycles", clr_total, 6);
        for (int k = 0; k < 3; k++) begin
            if (vt[k] >= W + 4) begin
                chk($sformatf("cont clr a w%0d", k), clr_log[vt[k] - W - 3], 1);
                chk($sformatf("cont clr b w%0d", k), clr_log[vt[k] - W - 2], 1);
            end
        end
        chk("cont busy end", busy, 0);

        // Abort in MEASURE cycle 50 (cycle 52 after the start edge).
        f1 = 32'd60;
        f2 = 32'd10;
        pulse_start();
        for (int c = 1; c < 52; c++) tick();
        chk("abort en before", an_en, 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort en", an_en, 0);
        chk("abort clr", an_clr, 0);
        chk("abort valid", valid, 0);
        begin
            int seen = 0;
            for (int c = 0; c < W + 20; c++) begin
                seen += int'(valid);
                tick();
            end
            chk("abort no result", seen, 0);
        end
        chk("abort keeps f1cap", f1_cap, 32'd0);
        chk("abort keeps symbol", symbol, 2'd2);

        // Asynchronous clear while a result is pending.
        ready = 1'b0;
        pulse_start();
        wait_valid("aclr");
        #2;
        clear = 1'b1;
        #1;
        check_all_zero("aclr");
        @(negedge clk);
        clear = 1'b0;
        ready = 1'b1;
        tick();
        chk("aclr stays idle", busy, 0);
        chk("aclr no valid", valid, 0);

        chk("sb drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
